// File: rtl/hs_rx_responder.sv
// hs_rx_responder
//   Clocked receiving end of a four-phase bundled-data Rreq/Rack channel.
//   Rreq is synchronised into clk, Rdata is captured into a one-entry buffer
//   and Rack is raised. Rack stays high until Rreq returns to zero. The
//   captured word is offered to local logic over dvalid/dready. A full buffer
//   stalls Rack until the word is consumed.
//
//   Optional feature macro: HS_RX_PARITY_EN (adds Rpar input and perr output,
//   even parity over {Rdata,Rpar}; perr=1 means error).
//
// Ports
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-high reset
//   Rreq    in   request from sender (asynchronous to clk)
//   Rdata   in   bundled data word
//   Rack    out  acknowledge to sender (registered)
//   dout    out  captured word (registered)
//   dvalid  out  dout holds an unconsumed word
//   dready  in   consumer accepts dout when dvalid & dready
//   Rpar    in   parity bit             (HS_RX_PARITY_EN only)
//   perr    out  parity error with dout (HS_RX_PARITY_EN only)
module hs_rx_responder #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2   // 2 or 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Rreq,
    input  logic [WIDTH-1:0] Rdata,
    output logic             Rack,
    output logic [WIDTH-1:0] dout,
    output logic             dvalid,
    input  logic             dready
`ifdef HS_RX_PARITY_EN
    ,
    input  logic             Rpar,
    output logic             perr
`endif
);

    typedef enum logic [1:0] {IDLE, STALL, ACK} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   rack_q, rack_d;
    logic                   dvalid_q, dvalid_d;
    logic [WIDTH-1:0]       dout_q, dout_d;
    logic                   take, buf_free, capture;

    // Rreq synchroniser; Rdata is not synchronised because the bundling
    // constraint keeps it stable from before Rreq rises until Rack rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], Rreq};
    end
    assign req_s = sync_q[SYNC_STAGES-1];

    assign take     = dvalid_q & dready;
    assign buf_free = ~dvalid_q | take;
    // Capture only on the way into ACK, so one handshake yields one word.
    assign capture  = ((state_q == IDLE) && req_s && buf_free) ||
                      ((state_q == STALL) && buf_free);

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rack_q   <= 1'b0;
            dvalid_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            rack_q   <= rack_d;
            dvalid_q <= dvalid_d;
            dout_q   <= dout_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_s) state_d = buf_free ? ACK : STALL;
            STALL:   if (buf_free) state_d = ACK;
            ACK:     if (!req_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next values; a capture wins over a simultaneous take.
    always_comb begin
        rack_d   = rack_q;
        dvalid_d = dvalid_q;
        dout_d   = dout_q;
        if (capture) begin
            rack_d   = 1'b1;
            dvalid_d = 1'b1;
            dout_d   = Rdata;
        end else begin
            if (take) dvalid_d = 1'b0;
            if ((state_q == ACK) && !req_s) rack_d = 1'b0;
        end
    end

    assign Rack   = rack_q;
    assign dvalid = dvalid_q;
    assign dout   = dout_q;

`ifdef HS_RX_PARITY_EN
    logic perr_q, perr_d;

    always_comb begin
        perr_d = perr_q;
        if (capture)   perr_d = ^{Rdata, Rpar};
        else if (take) perr_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) perr_q <= 1'b0;
        else     perr_q <= perr_d;
    end

    assign perr = perr_q;
`endif

endmodule

// File: tb/tb_hs_rx_responder.sv
module tb_hs_rx_responder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             Rreq;
    logic [WIDTH-1:0] Rdata;
    logic             Rack;
    logic [WIDTH-1:0] dout;
    logic             dvalid;
    logic             dready;
`ifdef HS_RX_PARITY_EN
    logic             Rpar;
    logic             perr;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    logic [WIDTH-1:0] got_q[$];
    logic             dv_drop;

    always #5 clk = ~clk;

    hs_rx_responder #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .Rreq   (Rreq),
        .Rdata  (Rdata),
        .Rack   (Rack),
        .dout   (dout),
        .dvalid (dvalid),
        .dready (dready)
`ifdef HS_RX_PARITY_EN
        ,
        .Rpar   (Rpar),
        .perr   (perr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one edge and settle; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        Rreq   = 1'b0;
        Rdata  = '0;
        dready = 1'b0;
`ifdef HS_RX_PARITY_EN
        Rpar   = 1'b0;
`endif
        #2;
        chk("rst_rack",   32'(Rack),   32'h0);
        chk("rst_dvalid", 32'(dvalid), 32'h0);
        chk("rst_dout",   32'(dout),   32'h0);
`ifdef HS_RX_PARITY_EN
        chk("rst_perr",   32'(perr),   32'h0);
`endif
        tick();
        rst = 1'b0;
        tick();

        // 1: free buffer, Rack rises 3 edges after Rreq, falls 3 after drop
        dready = 1'b1;
        Rdata  = 8'hA5;
        Rreq   = 1'b1;
        tick(); tick();
        chk("t1_rack_early", 32'(Rack), 32'h0);
        tick();
        chk("t1_rack_rise", 32'(Rack),   32'h1);
        chk("t1_dout",      32'(dout),   32'hA5);
        chk("t1_dvalid",    32'(dvalid), 32'h1);
        Rreq = 1'b0;
        tick();
        chk("t1_dvalid_taken", 32'(dvalid), 32'h0);
        tick();
        chk("t1_rack_hold", 32'(Rack), 32'h1);
        tick();
        chk("t1_rack_fall", 32'(Rack), 32'h0);

        // 2: back-pressure -> STALL, released by a one-cycle dready pulse
        dready = 1'b0;
        Rdata  = 8'h11;
        Rreq   = 1'b1;
        tick(); tick(); tick();
        chk("t2_rack_11", 32'(Rack), 32'h1);
        chk("t2_dout_11", 32'(dout), 32'h11);
        Rreq = 1'b0;
        tick(); tick(); tick();
        chk("t2_rack_fall", 32'(Rack), 32'h0);
        Rdata = 8'h22;
        Rreq  = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("t2_stall_rack", 32'(Rack),   32'h0);
        chk("t2_stall_dout", 32'(dout),   32'h11);
        chk("t2_stall_dv",   32'(dvalid), 32'h1);
        dready = 1'b1;
        tick();
        dready = 1'b0;
        chk("t2_rel_dout", 32'(dout),   32'h22);
        chk("t2_rel_dv",   32'(dvalid), 32'h1);
        chk("t2_rel_rack", 32'(Rack),   32'h1);
        Rreq = 1'b0;
        tick(); tick(); tick();
        chk("t2_rack_fall2", 32'(Rack), 32'h0);
        chk("t2_dv_held",    32'(dvalid), 32'h1);
        dready = 1'b1;
        tick();
        dready = 1'b0;
        chk("t2_drain", 32'(dvalid), 32'h0);

        // 3: capture and take in the same cycle, 16 back-to-back words
        dv_drop = 1'b0;
        got_q.delete();
        for (int i = 0; i < 16; i++) begin
            Rdata = 8'(i);
            Rreq  = 1'b1;
            tick();
            if (i > 0 && !dvalid) dv_drop = 1'b1;
            tick();
            if (i > 0 && !dvalid) dv_drop = 1'b1;
            // req_s is high in IDLE during this cycle; consume the old word now
            dready = 1'b1;
            if (dvalid) got_q.push_back(dout);
            tick();
            dready = 1'b0;
            if (!dvalid || !Rack || dout != 8'(i)) dv_drop = 1'b1;
            Rreq = 1'b0;
            tick(); tick(); tick();
            if (Rack || !dvalid) dv_drop = 1'b1;
        end
        dready = 1'b1;
        if (dvalid) got_q.push_back(dout);
        tick();
        dready = 1'b0;
        chk("t3_no_drop", 32'(dv_drop), 32'h0);
        chk("t3_count",   32'(got_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < got_q.size(); i++)
            chk($sformatf("t3_word%0d", i), 32'(got_q[i]), 32'(i));

        // 4: reset in ACK, then a still-high Rreq is a new request
        dready = 1'b0;
        Rdata  = 8'h5A;
        Rreq   = 1'b1;
        tick(); tick(); tick();
        chk("t4_rack_pre", 32'(Rack), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("t4_async_rack", 32'(Rack),   32'h0);
        chk("t4_async_dv",   32'(dvalid), 32'h0);
        chk("t4_async_dout", 32'(dout),   32'h0);
`ifdef HS_RX_PARITY_EN
        chk("t4_async_perr", 32'(perr),   32'h0);
`endif
        Rdata = 8'h3C;
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("t4_rack_early", 32'(Rack), 32'h0);
        tick();
        chk("t4_rack_rise", 32'(Rack), 32'h1);
        chk("t4_dout",      32'(dout), 32'h3C);
        Rreq = 1'b0;
        tick(); tick(); tick();
        chk("t4_rack_fall", 32'(Rack), 32'h0);

        // 5: parity words (timing and data checked in both builds)
        dready = 1'b1;
        Rdata  = 8'h01;
`ifdef HS_RX_PARITY_EN
        Rpar   = 1'b0;
`endif
        Rreq   = 1'b1;
        tick(); tick(); tick();
        chk("t5a_rack", 32'(Rack), 32'h1);
        chk("t5a_dout", 32'(dout), 32'h01);
        chk("t5a_dv",   32'(dvalid), 32'h1);
`ifdef HS_RX_PARITY_EN
        chk("t5a_perr", 32'(perr), 32'h1);
`endif
        Rreq = 1'b0;
        tick();
        chk("t5a_taken", 32'(dvalid), 32'h0);
`ifdef HS_RX_PARITY_EN
        chk("t5a_perr_clr", 32'(perr), 32'h0);
`endif
        tick(); tick();
        chk("t5a_rack_fall", 32'(Rack), 32'h0);
`ifdef HS_RX_PARITY_EN
        Rpar = 1'b1;
`endif
        Rreq = 1'b1;
        tick(); tick(); tick();
        chk("t5b_rack", 32'(Rack), 32'h1);
        chk("t5b_dv",   32'(dvalid), 32'h1);
`ifdef HS_RX_PARITY_EN
        chk("t5b_perr", 32'(perr), 32'h0);
`endif
        Rreq = 1'b0;
        tick(); tick(); tick();
        chk("t5b_rack_fall", 32'(Rack), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
